sdram_chip: RTL and testbench
=============================

SDRAM_CHIP -- requirements
Module: sdram_chip

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data width in bits; legal values are multiples of 8, and DW/8 is the byte-lane count NB.
REQ-002 SHALL have parameter ROW_W, default 13, meaning row address width.
REQ-003 SHALL have parameter COL_W, default 9, meaning column address width (COL_W<=10).
REQ-004 SHALL have parameter BA_W, default 2, meaning bank address width; bank count is 2^BA_W.
REQ-005 SHALL have parameter CL_RST, default 3, meaning CAS latency after reset.
REQ-006 SHALL have ports:
  - clk  in  1  clock, one clock only, all state on rising edge.
  - reset  in  1  synchronous, active-high reset.
  - cke  in  1  command enable.
  - cs  in  1  chip select, active low.
  - ras  in  1  row strobe, active low.
  - cas  in  1  column strobe, active low.
  - we  in  1  write enable, active low.
  - a  in  ROW_W  address and mode bus.
  - ba  in  BA_W  bank select.
  - dqm  in  NB  byte mask; 1 masks the lane.
  - dq  inout  DW  data bus; high-Z when not driving.
  - cmd_err  out  1  sticky illegal-command flag.

Function
REQ-007 SHALL decode a command at a rising edge only when cke=1 and cs=0, using {ras,cas,we}: 000 MODE, 001 REFRESH, 010 PRECHARGE, 011 ACTIVE, 100 WRITE, 101 READ, 110 BURST_STOP, 111 NOP. Any other edge is NOP.
REQ-008 SHALL keep a per-bank FSM with states IDLE and ACTIVE(row).
  - ACTIVE in IDLE: latch a as the open row and go to ACTIVE.
  - ACTIVE in ACTIVE: set cmd_err; no state change.
REQ-009 SHALL handle PRECHARGE as follows: a[10]=1 sets all banks IDLE; a[10]=0 sets bank ba IDLE. Precharging an IDLE bank is legal.
REQ-010 SHALL, on MODE, load a[2:0] as BL code, a[6:4] as CL code and a[9] as write-burst-single.
  - BL code 0/1/2/3 gives burst 1/2/4/8; other codes give 1.
  - CL code 2 gives CL=2; other codes give CL=3.
  - MODE while any burst is in progress sets cmd_err and is ignored.
REQ-011 SHALL treat READ/WRITE to an IDLE bank, and REFRESH with any bank ACTIVE, as: set cmd_err and ignore the command.
REQ-012 SHALL implement bursts as follows.
  - Start column is a[COL_W-1:0].
  - Beat k uses a column incrementing within the BL-aligned block (sequential wrap). Example: BL=4, start 6 gives 6,7,4,5.
  - Bank and row are those open at command time.
REQ-013 SHALL, for a READ at edge T, have the beat-k word driven on dq from edge T+CL-1+k through edge T+CL+k (the controller samples at T+CL+k); dqm SHALL be ignored for reads.
REQ-014 SHALL, for a WRITE at edge T, sample beat k at edge T+k.
  - Lanes with dqm[i]=0 are written; masked lanes keep old data.
  - With write-burst-single set, the burst length is 1.
  - dq is never driven during a write.
REQ-015 SHALL stop issuing further beats of the current burst, from the same edge, when READ, WRITE, BURST_STOP, or PRECHARGE of the burst's bank arrives. Read beats already in the CL delay line SHALL still be output.
REQ-016 SHALL give the new burst the bus when a READ/WRITE interrupts an earlier burst. If a write beat and a pending read beat collide, the write wins and that read beat is dropped.
REQ-017 SHALL treat REFRESH as a legal no-op on contents.
REQ-018 SHALL set cmd_err to 1 at the edge after an illegal command; it clears only on reset.

Reset
REQ-019 SHALL, with reset=1 at an edge, set:
  - all banks IDLE;
  - BL=1, CL=CL_RST, write-burst-single=0;
  - burst engine idle and read delay line flushed;
  - dq high-Z and cmd_err=0.
REQ-020 SHALL leave memory contents unaffected by reset.
REQ-021 SHALL let reset asserted mid-burst abort the burst at that edge, with no further dq drive or writes.

Structure
REQ-022 SHALL place the command encoding, bank-state enum and BL/CL decode constants in shared package sdram_pkg.
REQ-023 SHALL implement the per-bank FSM and open-row register as sub-module sdram_bank_ctrl, instantiated 2^BA_W times.
REQ-024 SHALL implement a single storage array of 2^(BA_W+ROW_W+COL_W) words of DW bits, addressed {bank,row,col}.

Verification
REQ-025 SHALL cover the read-latency case: MODE BL=4 CL=2; ACTIVE b1 r5; WRITE col 6 with data 0x1111..0x4444; READ col 6 at edge T -> 0x1111,0x2222,0x3333,0x4444 sampled at T+2..T+5 from cols 6,7,4,5.
REQ-026 SHALL cover the byte-mask case: DW=32; write 0xAABBCCDD over 0x11223344 with dqm=4'b0101 -> read back 0xAA22CC44.
REQ-027 SHALL cover burst stop: BL=8 CL=3 READ at T, BURST_STOP at T+2 -> exactly 2 beats, at T+3 and T+4, then dq high-Z.
REQ-028 SHALL cover illegal commands: READ to IDLE bank -> cmd_err=1 next edge, dq never driven; REFRESH with b0 ACTIVE -> cmd_err=1.
REQ-029 SHALL cover write-burst-single: BL=4 with a[9]=1; WRITE 4 cycles of data -> only the first column is changed.
REQ-030 SHALL cover reset mid-read: reset asserted at T+1 of a CL=3 read -> dq high-Z from T+1, cmd_err=0, contents preserved.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM chip model: command codes, bank states,
// and the mode-register decode helpers used by the top level.
package sdram_pkg;

    // Command encoding on {ras, cas, we} when the chip is selected
    typedef enum logic [2:0] {
        CMD_MODE       = 3'b000,
        CMD_REFRESH    = 3'b001,
        CMD_PRECHARGE  = 3'b010,
        CMD_ACTIVE     = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_READ       = 3'b101,
        CMD_BURST_STOP = 3'b110,
        CMD_NOP        = 3'b111
    } cmd_t;

    // Per-bank state: either closed or holding an open row
    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    localparam logic [3:0] BL_RESET = 4'd1;
    localparam logic [1:0] CL_TWO   = 2'd2;
    localparam logic [1:0] CL_THREE = 2'd3;

    // Burst-length code to beat count; unused codes fall back to a single beat
    function automatic logic [3:0] bl_decode(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    // CAS-latency code; only code 2 selects the short latency
    function automatic logic [1:0] cl_decode(input logic [2:0] code);
        return (code == 3'd2) ? CL_TWO : CL_THREE;
    endfunction

    // Column of a given beat: sequential wrap inside the BL-aligned block
    function automatic logic [9:0] burst_col(input logic [9:0] start,
                                             input logic [3:0] beat,
                                             input logic [3:0] bl);
        logic [9:0] mask;
        mask = 10'(bl) - 10'd1;
        return (start & ~mask) | ((start + 10'(beat)) & mask);
    endfunction

endpackage

// File: rtl/sdram_bank_ctrl.sv
// One bank's open/closed state machine together with its open-row register.
module sdram_bank_ctrl
    import sdram_pkg::*;
#(
    parameter int ROW_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic             precharge,
    input  logic [ROW_W-1:0] row_in,
    output bank_state_t      state,
    output logic [ROW_W-1:0] open_row
);

    bank_state_t next_state;

    // State register; reset closes the bank
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BANK_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Opening only happens from IDLE, closing only from ACTIVE
    always_comb begin
        next_state = state;
        case (state)
            BANK_IDLE:   if (activate)  next_state = BANK_ACTIVE;
            BANK_ACTIVE: if (precharge) next_state = BANK_IDLE;
            default:     next_state = BANK_IDLE;
        endcase
    end

    // Capture the row only when the bank actually opens
    always_ff @(posedge clk) begin
        if (reset) begin
            open_row <= '0;
        end else if (activate && (state == BANK_IDLE)) begin
            open_row <= row_in;
        end
    end

endmodule

// File: rtl/sdram_chip.sv
// Behavioural SDRAM device: command decode, per-bank row state, mode register,
// burst engine with CAS-latency read pipeline, and a byte-maskable array.
module sdram_chip
    import sdram_pkg::*;
#(
    parameter int DW     = 16,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int BA_W   = 2,
    parameter int CL_RST = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cke,
    input  logic              cs,
    input  logic              ras,
    input  logic              cas,
    input  logic              we,
    input  logic [ROW_W-1:0]  a,
    input  logic [BA_W-1:0]   ba,
    input  logic [DW/8-1:0]   dqm,
    inout  wire  [DW-1:0]     dq,
    output logic              cmd_err
);

    localparam int NB    = DW / 8;
    localparam int NBANK = 2 ** BA_W;
    localparam int AW    = BA_W + ROW_W + COL_W;
    localparam int DEPTH = 2 ** AW;

    cmd_t             cmd;
    bank_state_t      bank_state [NBANK];
    logic [ROW_W-1:0] open_row   [NBANK];
    logic             any_active;

    logic [3:0]       bl_q;
    logic [1:0]       cl_q;
    logic             wbs_q;

    logic             burst_active, burst_write;
    logic [BA_W-1:0]  burst_bank;
    logic [ROW_W-1:0] burst_row;
    logic [COL_W-1:0] burst_start;
    logic [3:0]       burst_len, burst_idx;

    logic             nxt_active, nxt_write;
    logic [BA_W-1:0]  nxt_bank;
    logic [ROW_W-1:0] nxt_row;
    logic [COL_W-1:0] nxt_start;
    logic [3:0]       nxt_len, nxt_idx;

    logic             issue_valid, issue_write;
    logic [BA_W-1:0]  issue_bank;
    logic [ROW_W-1:0] issue_row;
    logic [COL_W-1:0] issue_col;
    logic [9:0]       col_wide;
    logic [AW-1:0]    issue_addr;

    logic [2:0]       pipe_valid;
    logic [DW-1:0]    pipe_data [3];
    logic [DW-1:0]    mem [DEPTH];

    logic             sel_active, is_rw, legal_rw, burst_busy, illegal, stop_burst;
    logic             out_valid, drive;
    logic [DW-1:0]    out_data;

    assign cmd = (cke && !cs) ? cmd_t'({ras, cas, we}) : CMD_NOP;

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        sdram_bank_ctrl #(.ROW_W(ROW_W)) u_bank (
            .clk       (clk),
            .reset     (reset),
            .activate  ((cmd == CMD_ACTIVE) && (ba == BA_W'(i))),
            .precharge ((cmd == CMD_PRECHARGE) && (a[10] || (ba == BA_W'(i)))),
            .row_in    (a),
            .state     (bank_state[i]),
            .open_row  (open_row[i])
        );
    end

    // Legality checks: which commands are refused and flagged
    always_comb begin
        any_active = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (bank_state[i] == BANK_ACTIVE) any_active = 1'b1;
        end
        sel_active = (bank_state[ba] == BANK_ACTIVE);
        is_rw      = (cmd == CMD_READ) || (cmd == CMD_WRITE);
        legal_rw   = is_rw && sel_active;
        burst_busy = burst_active || (|pipe_valid);
        illegal    = ((cmd == CMD_ACTIVE) && sel_active)
                   || (is_rw && !sel_active)
                   || ((cmd == CMD_REFRESH) && any_active)
                   || ((cmd == CMD_MODE) && burst_busy);
        stop_burst = legal_rw || (cmd == CMD_BURST_STOP)
                   || ((cmd == CMD_PRECHARGE) && (a[10] || (ba == burst_bank)));
    end

    // Burst engine: a new READ/WRITE issues beat 0 now, otherwise continue the
    // running burst one beat per edge unless an interrupting command arrives
    always_comb begin
        issue_valid = 1'b0;
        issue_write = 1'b0;
        issue_bank  = burst_bank;
        issue_row   = burst_row;
        col_wide    = burst_col(10'(burst_start), burst_idx, burst_len);
        issue_col   = col_wide[COL_W-1:0];
        nxt_active  = burst_active;
        nxt_write   = burst_write;
        nxt_bank    = burst_bank;
        nxt_row     = burst_row;
        nxt_start   = burst_start;
        nxt_len     = burst_len;
        nxt_idx     = burst_idx;
        if (legal_rw) begin
            issue_valid = 1'b1;
            issue_write = (cmd == CMD_WRITE);
            issue_bank  = ba;
            issue_row   = open_row[ba];
            issue_col   = a[COL_W-1:0];
            nxt_len     = ((cmd == CMD_WRITE) && wbs_q) ? 4'd1 : bl_q;
            nxt_active  = (nxt_len > 4'd1);
            nxt_write   = (cmd == CMD_WRITE);
            nxt_bank    = ba;
            nxt_row     = open_row[ba];
            nxt_start   = a[COL_W-1:0];
            nxt_idx     = 4'd1;
        end else if (burst_active && !stop_burst) begin
            issue_valid = 1'b1;
            issue_write = burst_write;
            nxt_idx     = burst_idx + 4'd1;
            nxt_active  = (nxt_idx < burst_len);
        end else if (burst_active) begin
            nxt_active  = 1'b0;
        end
    end

    assign issue_addr = {issue_bank, issue_row, issue_col};

    // Control state: mode register, burst registers, read pipeline valids, error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            bl_q         <= BL_RESET;
            cl_q         <= 2'(CL_RST);
            wbs_q        <= 1'b0;
            burst_active <= 1'b0;
            burst_write  <= 1'b0;
            burst_bank   <= '0;
            burst_row    <= '0;
            burst_start  <= '0;
            burst_len    <= 4'd1;
            burst_idx    <= '0;
            pipe_valid   <= '0;
            cmd_err      <= 1'b0;
        end else begin
            if (illegal) cmd_err <= 1'b1;
            if ((cmd == CMD_MODE) && !illegal) begin
                bl_q  <= bl_decode(a[2:0]);
                cl_q  <= cl_decode(a[6:4]);
                wbs_q <= a[9];
            end
            burst_active <= nxt_active;
            burst_write  <= nxt_write;
            burst_bank   <= nxt_bank;
            burst_row    <= nxt_row;
            burst_start  <= nxt_start;
            burst_len    <= nxt_len;
            burst_idx    <= nxt_idx;
            pipe_valid   <= {pipe_valid[1:0], issue_valid && !issue_write};
        end
    end

    // Read data pipeline; contents are qualified by pipe_valid so need no reset
    always_ff @(posedge clk) begin
        pipe_data[0] <= mem[issue_addr];
        pipe_data[1] <= pipe_data[0];
        pipe_data[2] <= pipe_data[1];
    end

    // Array write with per-lane masking; storage survives reset
    always_ff @(posedge clk) begin
        if (!reset && issue_valid && issue_write) begin
            for (int i = 0; i < NB; i++) begin
                if (!dqm[i]) mem[issue_addr][i*8 +: 8] <= dq[i*8 +: 8];
            end
        end
    end

    // Tap the pipeline at the CAS latency; a write beat takes the bus over a read beat
    always_comb begin
        out_valid = (cl_q == CL_TWO) ? pipe_valid[1] : pipe_valid[2];
        out_data  = (cl_q == CL_TWO) ? pipe_data[1]  : pipe_data[2];
        drive     = out_valid && !(issue_valid && issue_write);
    end

    assign dq = drive ? out_data : {DW{1'bz}};

endmodule

// File: tb/tb_sdram_chip.sv
// Directed bench for sdram_chip: read beats are queued with the edge at which
// they must be sampled and matched as the clock advances; all other cycles
// expect a released bus.
module tb_sdram_chip;
    import sdram_pkg::*;

    localparam int DW    = 32;
    localparam int ROW_W = 11;
    localparam int COL_W = 8;
    localparam int BA_W  = 2;

    logic             clk = 1'b0;
    logic             reset, cke, cs, ras, cas, we;
    logic [ROW_W-1:0] a;
    logic [BA_W-1:0]  ba;
    logic [3:0]       dqm;
    wire  [DW-1:0]    dq;
    logic             cmd_err;

    logic             tb_oe;
    logic [DW-1:0]    tb_dq;

    typedef struct {
        int            edge_no;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sb[$];
    int    edge_cnt   = 0;
    int    assert_cnt = 0;
    int    fail_cnt   = 0;
    logic  exp_err    = 1'b0;

    assign dq = tb_oe ? tb_dq : {DW{1'bz}};

    always #5 clk = ~clk;

    // Count rising edges; between edges this is the index of the next one
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sdram_chip #(
        .DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .CL_RST(3)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke), .cs(cs), .ras(ras), .cas(cas),
        .we(we), .a(a), .ba(ba), .dqm(dqm), .dq(dq), .cmd_err(cmd_err)
    );

    task automatic check_output(input string tag, input logic [DW-1:0] obs,
                                input logic [DW-1:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle, check, advance to next falling edge
    task automatic apply_stimulus(input cmd_t c, input logic [BA_W-1:0] bank,
                                  input logic [ROW_W-1:0] addr, input logic [3:0] mask,
                                  input logic drv, input logic [DW-1:0] wdata,
                                  input logic illegal, input logic rst);
        reset = rst;
        cs    = 1'b0;
        {ras, cas, we} = c;
        ba    = bank;
        a     = addr;
        dqm   = mask;
        tb_oe = drv;
        tb_dq = wdata;
        #1;
        check_output("cmd_err", {{(DW-1){1'b0}}, cmd_err}, {{(DW-1){1'b0}}, exp_err});
        if ((sb.size() > 0) && (sb[0].edge_no == edge_cnt)) begin
            check_output("rd_beat", dq, sb[0].data);
            void'(sb.pop_front());
        end else if (drv) begin
            check_output("wr_bus", dq, wdata);
        end else begin
            check_output("hiz", dq, {DW{1'bz}});
        end
        @(posedge clk);
        if (illegal) exp_err = 1'b1;
        if (rst) begin
            exp_err = 1'b0;
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(CMD_NOP, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic cmd_step(input cmd_t c, input logic [BA_W-1:0] bank,
                            input logic [ROW_W-1:0] addr, input logic illegal);
        apply_stimulus(c, bank, addr, 4'b0000, 1'b0, '0, illegal, 1'b0);
    endtask

    task automatic do_reset();
        apply_stimulus(CMD_NOP, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    // WRITE followed by n-1 NOP cycles that keep presenting data
    task automatic write_burst(input logic [BA_W-1:0] bank, input logic [ROW_W-1:0] col,
                               input int n, input logic [3:0] mask,
                               input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] w [4];
        w = '{w0, w1, w2, w3};
        apply_stimulus(CMD_WRITE, bank, col, mask, 1'b1, w[0], 1'b0, 1'b0);
        for (int k = 1; k < n; k++) apply_stimulus(CMD_NOP, '0, '0, mask, 1'b1, w[k], 1'b0, 1'b0);
    endtask

    // READ issued at the coming edge T; beat k expected at edge T+cl+k
    task automatic read_expect(input logic [BA_W-1:0] bank, input logic [ROW_W-1:0] col,
                               input int cl, input int n,
                               input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] w [4];
        beat_t b;
        w = '{w0, w1, w2, w3};
        for (int k = 0; k < n; k++) begin
            b.edge_no = edge_cnt + cl + k;
            b.data    = w[k];
            sb.push_back(b);
        end
        cmd_step(CMD_READ, bank, col, 1'b0);
    endtask

    function automatic logic [ROW_W-1:0] mode_word(input logic [2:0] bl, input logic [2:0] cl,
                                                   input logic wbs);
        logic [ROW_W-1:0] m;
        m      = '0;
        m[2:0] = bl;
        m[6:4] = cl;
        m[9]   = wbs;
        return m;
    endfunction

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; cke = 1'b1; cs = 1'b1; ras = 1'b1; cas = 1'b1; we = 1'b1;
        a = '0; ba = '0; dqm = '0; tb_oe = 1'b0; tb_dq = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nop(2);

        // Read latency and column wrap: BL=4 CL=2, write cols 6,7,4,5
        cmd_step(CMD_MODE, '0, mode_word(3'd2, 3'd2, 1'b0), 1'b0);
        cmd_step(CMD_ACTIVE, 2'd1, 11'd5, 1'b0);
        write_burst(2'd1, 11'd6, 4, 4'b0000, 32'h1111, 32'h2222, 32'h3333, 32'h4444);
        read_expect(2'd1, 11'd6, 2, 4, 32'h1111, 32'h2222, 32'h3333, 32'h4444);
        nop(6);
        read_expect(2'd1, 11'd4, 2, 4, 32'h3333, 32'h4444, 32'h1111, 32'h2222);
        nop(6);

        // Byte mask: masked lanes keep their old bytes
        cmd_step(CMD_MODE, '0, mode_word(3'd0, 3'd2, 1'b0), 1'b0);
        cmd_step(CMD_ACTIVE, 2'd2, 11'd7, 1'b0);
        write_burst(2'd2, 11'd3, 1, 4'b0000, 32'h11223344, '0, '0, '0);
        write_burst(2'd2, 11'd3, 1, 4'b0101, 32'hAABBCCDD, '0, '0, '0);
        read_expect(2'd2, 11'd3, 2, 1, 32'hAA22CC44, '0, '0, '0);
        nop(4);

        // Write-burst-single: only the first column of a 4-cycle write changes
        cmd_step(CMD_MODE, '0, mode_word(3'd2, 3'd2, 1'b0), 1'b0);
        write_burst(2'd2, 11'd8, 4, 4'b0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        cmd_step(CMD_MODE, '0, mode_word(3'd2, 3'd2, 1'b1), 1'b0);
        write_burst(2'd2, 11'd8, 4, 4'b0000, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        read_expect(2'd2, 11'd8, 2, 4, 32'hB0, 32'hA1, 32'hA2, 32'hA3);
        nop(6);

        // Burst stop: BL=8 CL=3, stop two edges after READ leaves two beats
        cmd_step(CMD_MODE, '0, mode_word(3'd3, 3'd3, 1'b0), 1'b0);
        read_expect(2'd1, 11'd4, 3, 2, 32'h3333, 32'h4444, '0, '0);
        nop(1);
        cmd_step(CMD_BURST_STOP, '0, '0, 1'b0);
        nop(6);

        // Refresh legality and all-bank precharge
        do_reset();
        cmd_step(CMD_REFRESH, '0, '0, 1'b0);
        cmd_step(CMD_ACTIVE, 2'd0, 11'd1, 1'b0);
        cmd_step(CMD_ACTIVE, 2'd3, 11'd2, 1'b0);
        cmd_step(CMD_PRECHARGE, '0, 11'h400, 1'b0);
        cmd_step(CMD_REFRESH, '0, '0, 1'b0);
        cmd_step(CMD_ACTIVE, 2'd0, 11'd1, 1'b0);
        cmd_step(CMD_REFRESH, '0, '0, 1'b1);
        nop(2);

        // READ to an idle bank and ACTIVE to an open bank are both refused
        do_reset();
        cmd_step(CMD_READ, 2'd3, '0, 1'b1);
        nop(4);
        do_reset();
        cmd_step(CMD_ACTIVE, 2'd0, 11'd1, 1'b0);
        cmd_step(CMD_ACTIVE, 2'd0, 11'd2, 1'b1);
        nop(2);

        // Single-bank precharge closes only that bank; then reset mid-read
        do_reset();
        cmd_step(CMD_ACTIVE, 2'd1, 11'd5, 1'b0);
        cmd_step(CMD_ACTIVE, 2'd2, 11'd7, 1'b0);
        cmd_step(CMD_PRECHARGE, 2'd2, 11'd0, 1'b0);
        cmd_step(CMD_READ, 2'd2, 11'd3, 1'b1);
        cmd_step(CMD_MODE, '0, mode_word(3'd2, 3'd3, 1'b0), 1'b0);
        read_expect(2'd1, 11'd4, 3, 4, 32'h3333, 32'h4444, 32'h1111, 32'h2222);
        do_reset();
        nop(5);

        // Contents survive reset (BL=1, CL=3 after reset)
        cmd_step(CMD_ACTIVE, 2'd1, 11'd5, 1'b0);
        read_expect(2'd1, 11'd6, 3, 1, 32'h1111, '0, '0, '0);
        nop(4);
        read_expect(2'd1, 11'd5, 3, 1, 32'h4444, '0, '0, '0);
        nop(4);
        cmd_step(CMD_ACTIVE, 2'd2, 11'd7, 1'b0);
        read_expect(2'd2, 11'd3, 3, 1, 32'hAA22CC44, '0, '0, '0);
        nop(4);
        read_expect(2'd2, 11'd9, 3, 1, 32'hA1, '0, '0, '0);
        nop(4);

        check_output("sb_empty", DW'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
